// File: rtl/trap_peak_extractor.sv
// Pulse peak extractor for trapezoidal-filter output.
// Emits one record per threshold-crossing event: scaled/saturated peak, timestamp, pile-up flag.
module trap_peak_extractor #(
  parameter int unsigned IN_W        = 24,
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned MAX_WIDTH   = 64,
  parameter int unsigned HOLDOFF_LEN = 16,
  parameter int unsigned TS_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  threshold,
  output logic [OUT_W-1:0] out_amp,
  output logic [TS_W-1:0]  out_ts,
  output logic             out_pileup,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned WW = $clog2(MAX_WIDTH + 1);
  localparam int unsigned HW = $clog2(HOLDOFF_LEN + 1);
  localparam int unsigned SW = (IN_W > OUT_W) ? IN_W : OUT_W;
  localparam logic [WW-1:0] MaxWidth = WW'(MAX_WIDTH);
  localparam logic [HW-1:0] HoldLast = HW'(HOLDOFF_LEN - 1);
  localparam logic signed [SW-1:0] SatHi = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SatLo = ~SatHi;

  typedef enum logic [1:0] {StIdle, StRise, StHold} state_e;

  state_e                 r_state, w_state_d;
  logic [TS_W-1:0]        r_cnt, r_ts, w_ts_d;
  logic signed [IN_W-1:0] r_thr, r_max, w_max_d, w_data;
  logic [WW-1:0]          r_width, w_width_d;
  logic [HW-1:0]          r_hold, w_hold_d;
  logic                   w_above, w_emit, w_pileup;
  logic signed [IN_W-1:0] w_scaled;
  logic signed [SW-1:0]   w_scaled_x;
  logic [OUT_W-1:0]       w_amp;
  logic [OUT_W-1:0]       r_out_amp;
  logic [TS_W-1:0]        r_out_ts;
  logic                   r_out_pileup, r_out_valid;

  assign w_data  = in_data;
  assign w_above = w_data > r_thr;

  always_comb begin
    w_state_d = r_state;
    w_max_d   = r_max;
    w_ts_d    = r_ts;
    w_width_d = r_width;
    w_hold_d  = r_hold;
    w_emit    = 1'b0;
    w_pileup  = 1'b0;
    if (in_valid) begin
      unique case (r_state)
        StIdle: begin
          if (w_above) begin
            w_state_d = StRise;
            w_max_d   = w_data;
            w_ts_d    = r_cnt;
            w_width_d = WW'(1);
          end
        end
        StRise: begin
          if (w_above) begin
            // Strict compare keeps the earliest sample of a flat top.
            if (w_data > r_max) begin
              w_max_d = w_data;
              w_ts_d  = r_cnt;
            end
            w_width_d = r_width + 1'b1;
            if (w_width_d == MaxWidth) begin
              w_emit    = 1'b1;
              w_pileup  = 1'b1;
              w_state_d = StHold;
              w_hold_d  = '0;
            end
          end else begin
            w_emit    = 1'b1;
            w_state_d = StHold;
            w_hold_d  = '0;
          end
        end
        StHold: begin
          if (r_hold == HoldLast) begin
            if (!w_above) w_state_d = StIdle;
          end else begin
            w_hold_d = r_hold + 1'b1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  assign w_scaled   = w_max_d >>> SHIFT;
  assign w_scaled_x = SW'(w_scaled);

  always_comb begin
    w_amp = w_scaled_x[OUT_W-1:0];
    if (w_scaled_x > SatHi)      w_amp = SatHi[OUT_W-1:0];
    else if (w_scaled_x < SatLo) w_amp = SatLo[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_thr        <= threshold;
      r_max        <= '0;
      r_ts         <= '0;
      r_width      <= '0;
      r_hold       <= '0;
      r_out_amp    <= '0;
      r_out_ts     <= '0;
      r_out_pileup <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      // Trigger level tracks the input only while waiting for a pulse.
      if (r_state == StIdle) r_thr <= threshold;
      if (in_valid) r_cnt <= r_cnt + 1'b1;
      r_state     <= w_state_d;
      r_max       <= w_max_d;
      r_ts        <= w_ts_d;
      r_width     <= w_width_d;
      r_hold      <= w_hold_d;
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_amp    <= w_amp;
        r_out_ts     <= w_ts_d;
        r_out_pileup <= w_pileup;
      end
    end
  end

  assign out_amp    = r_out_amp;
  assign out_ts     = r_out_ts;
  assign out_pileup = r_out_pileup;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != StIdle);

endmodule
